cache_arbiter: RTL and testbench

Arbitrates the single line-granularity memory port, served by the cacheline adaptor, between a split instruction cache and data cache. The block accepts independent 256-bit line read requests from the I-cache and read/write requests from the D-cache. It grants one requester at a time, registers that requester's command toward the adaptor, and routes the adaptor response back to the granted cache only. It sits between the two cache `pmem_*` ports and the adaptor `line_*` / `address_i` / `read_i` / `write_i` / `resp_o` port.

---
 rtl/cache_arbiter_pkg.sv | 6 +
 rtl/cache_arbiter_if.sv | 27 ++
 rtl/cache_arbiter_grant_sel.sv | 15 +
 rtl/cache_arbiter.sv | 72 +++++++
 tb/tb_cache_arbiter.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/cache_arbiter_pkg.sv
// rv32i_types: shared cache-side types, including the arbiter's FSM state and grant owner.
package rv32i_types;
    typedef logic [255:0] cacheline_t;
    typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} arb_state_t;
    typedef enum logic {GRANT_I, GRANT_D} grant_t;
endpackage

// File: rtl/cache_arbiter_if.sv
// cache_arbiter_if: I-cache, D-cache and adaptor line ports seen by the arbiter.
interface cache_arbiter_if #(parameter int LINE_W = 256, parameter int ADDR_W = 32);
    logic [ADDR_W-1:0] i_address;
    logic              i_read;
    logic [LINE_W-1:0] i_rdata;
    logic              i_resp;
    logic [ADDR_W-1:0] d_address;
    logic              d_read;
    logic              d_write;
    logic [LINE_W-1:0] d_wdata;
    logic [LINE_W-1:0] d_rdata;
    logic              d_resp;
    logic [ADDR_W-1:0] mem_address;
    logic              mem_read;
    logic              mem_write;
    logic [LINE_W-1:0] mem_wdata;
    logic [LINE_W-1:0] mem_rdata;
    logic              mem_resp;
    modport slave (
        input  i_address, i_read, d_address, d_read, d_write, d_wdata, mem_rdata, mem_resp,
        output i_rdata, i_resp, d_rdata, d_resp, mem_address, mem_read, mem_write, mem_wdata
    );
    modport master (
        output i_address, i_read, d_address, d_read, d_write, d_wdata, mem_rdata, mem_resp,
        input  i_rdata, i_resp, d_rdata, d_resp, mem_address, mem_read, mem_write, mem_wdata
    );
endinterface

// File: rtl/cache_arbiter_grant_sel.sv
// arb_grant_sel: picks I or D from the pending requests; ties go to D, or alternate when RR=1.
module arb_grant_sel
    import rv32i_types::*;
#(
    parameter bit RR = 1'b0
) (
    input  logic   i_req,
    input  logic   d_req,
    input  grant_t last_grant,
    output logic   grant_i,
    output logic   grant_d
);
    assign grant_d = d_req && (!i_req || !RR || last_grant == GRANT_I);
    assign grant_i = i_req && !grant_d;
endmodule

// File: rtl/cache_arbiter.sv
// cache_arbiter: shares the single line-granularity memory port between I-cache and D-cache.
module cache_arbiter
    import rv32i_types::*;
#(
    parameter int LINE_W = 256,
    parameter int ADDR_W = 32,
    parameter bit RR     = 1'b0
) (
    input logic            clk,
    input logic            rst,
    cache_arbiter_if.slave bus
);
    arb_state_t        state, next;
    grant_t            last_grant;
    logic              grant_i, grant_d, start, done;
    logic [ADDR_W-1:0] addr_q;
    logic [LINE_W-1:0] wdata_q;
    logic              read_q, write_q;

    arb_grant_sel #(.RR(RR)) u_sel (
        .i_req      (bus.i_read),
        .d_req      (bus.d_read || bus.d_write),
        .last_grant (last_grant),
        .grant_i    (grant_i),
        .grant_d    (grant_d)
    );

    assign start = state == IDLE && (grant_i || grant_d);
    assign done  = state != IDLE && bus.mem_resp;

    always_ff @(posedge clk) begin
        state <= rst ? IDLE : next;
    end

    always_comb begin
        next = (state == IDLE) ? (grant_d ? SERVE_D : grant_i ? SERVE_I : IDLE)
                               : (bus.mem_resp ? IDLE : state);
    end

    always_comb begin
        bus.i_resp      = state == SERVE_I && bus.mem_resp;
        bus.d_resp      = state == SERVE_D && bus.mem_resp;
        bus.i_rdata     = bus.mem_rdata;
        bus.d_rdata     = bus.mem_rdata;
        bus.mem_address = addr_q;
        bus.mem_read    = read_q;
        bus.mem_write   = write_q;
        bus.mem_wdata   = wdata_q;
    end

    // Command is frozen at grant so later requester changes cannot disturb the adaptor.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q     <= '0;
            wdata_q    <= '0;
            read_q     <= 1'b0;
            write_q    <= 1'b0;
            last_grant <= GRANT_I;
        end else if (start) begin
            addr_q  <= grant_d ? bus.d_address : bus.i_address;
            wdata_q <= grant_d ? bus.d_wdata : '0;
            read_q  <= grant_i || !bus.d_write;
            write_q <= grant_d && bus.d_write;
        end else if (done) begin
            read_q     <= 1'b0;
            write_q    <= 1'b0;
            last_grant <= (state == SERVE_D) ? GRANT_D : GRANT_I;
        end
    end

    assert property (@(posedge clk) disable iff (rst) !(bus.d_read && bus.d_write));
endmodule

// File: tb/tb_cache_arbiter.sv
// tb_cache_arbiter: directed checks of a fixed-priority (u0) and a round-robin (u1) arbiter.
module tb_cache_arbiter;
    import rv32i_types::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [31:0] i_address = '0, d_address = '0;
    logic       i_read = 1'b0, d_read = 1'b0, d_write = 1'b0, mem_resp = 1'b0;
    cacheline_t d_wdata = '0, mem_rdata = '0;
    cacheline_t line_a5, line_w, line_3c, line_77;
    int total = 0, bad = 0;

    always #5 clk = ~clk;

    cache_arbiter_if b0 ();
    cache_arbiter_if b1 ();

    assign b0.i_address = i_address;  assign b1.i_address = i_address;
    assign b0.i_read    = i_read;     assign b1.i_read    = i_read;
    assign b0.d_address = d_address;  assign b1.d_address = d_address;
    assign b0.d_read    = d_read;     assign b1.d_read    = d_read;
    assign b0.d_write   = d_write;    assign b1.d_write   = d_write;
    assign b0.d_wdata   = d_wdata;    assign b1.d_wdata   = d_wdata;
    assign b0.mem_rdata = mem_rdata;  assign b1.mem_rdata = mem_rdata;
    assign b0.mem_resp  = mem_resp;   assign b1.mem_resp  = mem_resp;

    cache_arbiter #(.RR(1'b0)) u0 (.clk(clk), .rst(rst), .bus(b0));
    cache_arbiter #(.RR(1'b1)) u1 (.clk(clk), .rst(rst), .bus(b1));

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        line_a5 = {32{8'hA5}};
        line_w  = {8{32'hDEAD_BEEF}};
        line_3c = {32{8'h3C}};
        line_77 = {32{8'h77}};

        // reset values
        tick(); tick();
        chk("rst_mem_read", b0.mem_read, 0);
        chk("rst_mem_write", b0.mem_write, 0);
        chk("rst_mem_address", b0.mem_address, 0);
        chk("rst_mem_wdata", b0.mem_wdata, 0);
        chk("rst_resp", {b0.i_resp, b0.d_resp, b1.i_resp, b1.d_resp}, 0);
        rst = 1'b0;

        // lone I read, adaptor answers 4 cycles after the request
        tick();
        i_read = 1'b1; i_address = 32'h0000_0060;
        tick(); #1;
        chk("lone_mem_read", b0.mem_read, 1);
        chk("lone_mem_address", b0.mem_address, 32'h60);
        chk("lone_i_resp_early", b0.i_resp, 0);
        tick(); tick(); tick();
        mem_resp = 1'b1; mem_rdata = line_a5; #1;
        chk("lone_i_resp", b0.i_resp, 1);
        chk("lone_i_rdata", b0.i_rdata, line_a5);
        chk("lone_d_resp", b0.d_resp, 0);
        tick();
        mem_resp = 1'b0; i_read = 1'b0; #1;
        chk("lone_i_resp_pulse", b0.i_resp, 0);
        chk("lone_mem_read_low", b0.mem_read, 0);

        // simultaneous I read and D write, fixed priority
        tick();
        i_read = 1'b1; i_address = 32'h0000_0080;
        d_write = 1'b1; d_address = 32'h0000_1000; d_wdata = line_w;
        tick(); #1;
        chk("tie_mem_write", b0.mem_write, 1);
        chk("tie_mem_read", b0.mem_read, 0);
        chk("tie_mem_address", b0.mem_address, 32'h1000);
        chk("tie_mem_wdata", b0.mem_wdata, line_w);
        tick();
        mem_resp = 1'b1; #1;
        chk("tie_d_resp", b0.d_resp, 1);
        chk("tie_i_resp", b0.i_resp, 0);
        tick();
        mem_resp = 1'b0; d_write = 1'b0; #1;
        chk("tie_idle_gap", {b0.mem_read, b0.mem_write}, 0);
        tick(); #1;
        chk("tie_i_issue_read", b0.mem_read, 1);
        chk("tie_i_issue_addr", b0.mem_address, 32'h80);
        mem_resp = 1'b1; mem_rdata = line_3c; #1;
        chk("tie_i_resp2", b0.i_resp, 1);
        chk("tie_i_rdata2", b0.i_rdata, line_3c);
        tick();
        mem_resp = 1'b0; i_read = 1'b0;

        // three consecutive ties: u1 alternates D, I, D while u0 stays on D
        rst = 1'b1; tick(); rst = 1'b0;
        i_read = 1'b1; i_address = 32'h0000_3000;
        d_read = 1'b1; d_address = 32'h0000_2000;
        for (int r = 0; r < 3; r++) begin
            tick(); #1;
            chk($sformatf("rr%0d_u1_addr", r), b1.mem_address, (r == 1) ? 32'h3000 : 32'h2000);
            chk($sformatf("rr%0d_u0_addr", r), b0.mem_address, 32'h2000);
            mem_resp = 1'b1; #1;
            chk($sformatf("rr%0d_u1_resp", r), {b1.i_resp, b1.d_resp}, (r == 1) ? 2'b10 : 2'b01);
            chk($sformatf("rr%0d_u0_resp", r), {b0.i_resp, b0.d_resp}, 2'b01);
            tick();
            mem_resp = 1'b0;
            if (r == 2) begin i_read = 1'b0; d_read = 1'b0; end
            #1;
            chk($sformatf("rr%0d_gap", r), b1.mem_read, 0);
        end

        // stray response while idle
        tick();
        mem_resp = 1'b1; #1;
        chk("stray_resp", {b0.i_resp, b0.d_resp, b1.i_resp, b1.d_resp}, 0);
        tick();
        mem_resp = 1'b0; #1;
        chk("stray_cmd", {b0.mem_read, b0.mem_write}, 0);
        i_read = 1'b1; i_address = 32'h0000_0040;
        tick(); #1;
        chk("stray_then_grant", b0.mem_read, 1);
        chk("stray_then_addr", b0.mem_address, 32'h40);
        mem_resp = 1'b1; #1;
        chk("stray_then_resp", b0.i_resp, 1);
        tick();
        mem_resp = 1'b0; i_read = 1'b0;

        // reset in cycle 2 of a D read
        tick();
        d_read = 1'b1; d_address = 32'h0000_4000;
        tick(); #1;
        chk("mid_rst_issue", b0.mem_read, 1);
        chk("mid_rst_wdata", b0.mem_wdata, line_w);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0; d_read = 1'b0; #1;
        chk("mid_rst_mem_read", b0.mem_read, 0);
        chk("mid_rst_mem_address", b0.mem_address, 0);
        chk("mid_rst_mem_wdata", b0.mem_wdata, 0);
        chk("mid_rst_resp", {b0.i_resp, b0.d_resp}, 0);
        i_read = 1'b1; i_address = 32'h0000_0060;
        tick(); #1;
        chk("post_rst_read", b0.mem_read, 1);
        mem_resp = 1'b1; mem_rdata = line_77; #1;
        chk("post_rst_resp", b0.i_resp, 1);
        chk("post_rst_rdata", b0.i_rdata, line_77);
        tick();
        mem_resp = 1'b0; i_read = 1'b0;

        // request dropped after grant still completes
        tick();
        i_read = 1'b1; i_address = 32'h0000_0100;
        tick();
        i_read = 1'b0;
        tick(); #1;
        chk("drop_mem_read_held", b0.mem_read, 1);
        chk("drop_addr_held", b0.mem_address, 32'h100);
        mem_resp = 1'b1; #1;
        chk("drop_i_resp", b0.i_resp, 1);
        tick();
        mem_resp = 1'b0; #1;
        chk("drop_i_resp_once", b0.i_resp, 0);
        chk("drop_mem_read_low", b0.mem_read, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
